jtopl_slot_ring: RTL and testbench

//  Recirculating time-multiplexed slot store: STAGES slots of WIDTH bits circulate one

---
 rtl/jtopl_slot_ring_pkg.sv | 15 +
 rtl/jtopl_slot_ring_cnt.sv | 27 ++
 rtl/jtopl_slot_ring.sv | 131 +++++++++++++
 tb/tb_jtopl_slot_ring.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_slot_ring_pkg.sv
// Shared definitions for the recirculating slot ring.
//   STAGES_DEF : default number of slots in the ring
//   SW_DEF     : slot index width for the default ring size
//   W_* / R_*  : write / read request FSM state encodings
package jtopl_slot_ring_pkg;

  localparam int STAGES_DEF = 18;
  localparam int SW_DEF     = $clog2(STAGES_DEF);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_WAIT = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_WAIT = 1'b1;

endpackage

// File: rtl/jtopl_slot_ring_cnt.sv
// Mod-STAGES slot counter. Advances one step per cen, wraps STAGES-1 -> 0.
//   rst  : async reset, active-high (counter -> 0)
//   clk  : clock
//   cen  : advance enable
//   slot : current slot index
module jtopl_slot_cnt
  import jtopl_slot_ring_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int SW     = SW_DEF
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  output logic [SW-1:0] slot
);

  localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      slot <= '0;
    else if (cen)
      slot <= (slot == LAST) ? '0 : slot + 1'b1;
  end

endmodule

// File: rtl/jtopl_slot_ring.sv
// Recirculating time-multiplexed slot store. STAGES slots of WIDTH bits
// circulate one position per cen; the head value feeds back to the tail.
// Host ports inject (write) or capture (read) one slot when it passes the head.
//   rst, clk                  : async active-high reset, clock
//   cen                       : ring advance enable
//   slot, dout                : index and value of the slot now at the head
//   wr_req/wr_slot/wr_data    : write request (sampled when !wr_busy)
//   wr_busy/wr_ack/wr_err     : write pending / done pulse / out-of-range flag
//   rd_req/rd_slot            : read request (sampled when !rd_busy)
//   rd_busy/rd_valid/rd_data  : read pending / data pulse / captured value
module jtopl_slot_ring
  import jtopl_slot_ring_pkg::*;
#(
  parameter int   WIDTH  = 5,
  parameter int   STAGES = STAGES_DEF,
  parameter logic RSTVAL = 1'b0,
  parameter int   SW     = SW_DEF
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             cen,
  output logic [SW-1:0]    slot,
  output logic [WIDTH-1:0] dout,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic             rd_busy,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [WIDTH-1:0] RVAL  = {WIDTH{RSTVAL}};
  localparam logic [SW:0]      NSLOT = (SW+1)'(STAGES);

  logic [WIDTH-1:0] ring [STAGES];
  logic [0:0]       wst, rst_q;
  logic [SW-1:0]    wr_slot_q, rd_slot_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             inj, rhit, wr_oor, rd_oor;

  jtopl_slot_cnt #(.STAGES(STAGES), .SW(SW)) u_cnt (
    .rst  (rst),
    .clk  (clk),
    .cen  (cen),
    .slot (slot)
  );

  assign dout    = ring[STAGES-1];
  assign wr_busy = (wst == W_WAIT);
  assign rd_busy = (rst_q == R_WAIT);
  assign wr_oor  = {1'b0, wr_slot} >= NSLOT;
  assign rd_oor  = {1'b0, rd_slot} >= NSLOT;

  // Matches use the registered target, so a request accepted on the same
  // edge as a matching cen only hits on the next revolution.
  assign inj  = (wst == W_WAIT) && cen && (slot == wr_slot_q);
  assign rhit = (rst_q == R_WAIT) && cen && (slot == rd_slot_q);

  // ring[STAGES-1] is the head; ring[0] is the tail that receives the
  // recirculated head or the injected write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) ring[i] <= RVAL;
    end else if (cen) begin
      ring[0] <= inj ? wr_data_q : ring[STAGES-1];
      for (int i = 1; i < STAGES; i++) ring[i] <= ring[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst       <= W_IDLE;
      wr_slot_q <= '0;
      wr_data_q <= RVAL;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (wst == W_IDLE) begin
        if (wr_req) begin
          wr_slot_q <= wr_slot;
          wr_data_q <= wr_data;
          if (wr_oor) begin
            wr_ack <= 1'b1;
            wr_err <= 1'b1;
          end else begin
            wst <= W_WAIT;
          end
        end
      end else if (inj) begin
        wst    <= W_IDLE;
        wr_ack <= 1'b1;
      end
    end
  end

  // Capture happens from the pre-advance head, so a write landing on the
  // same slot in the same cen is not yet visible to the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q     <= R_IDLE;
      rd_slot_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= RVAL;
    end else begin
      rd_valid <= 1'b0;
      if (rst_q == R_IDLE) begin
        if (rd_req) begin
          rd_slot_q <= rd_slot;
          if (rd_oor) begin
            rd_valid <= 1'b1;
            rd_data  <= RVAL;
          end else begin
            rst_q <= R_WAIT;
          end
        end
      end else if (rhit) begin
        rst_q    <= R_IDLE;
        rd_valid <= 1'b1;
        rd_data  <= dout;
      end
    end
  end

endmodule

// File: tb/tb_jtopl_slot_ring.sv
module tb_jtopl_slot_ring;
  localparam int WIDTH  = 5;
  localparam int STAGES = 18;
  localparam int SW     = 5;

  logic             rst = 1'b1, clk = 1'b0, cen = 1'b0;
  logic             wr_req = 1'b0, rd_req = 1'b0;
  logic [SW-1:0]    wr_slot = '0, rd_slot = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [SW-1:0]    slot;
  logic [WIDTH-1:0] dout, rd_data;
  logic             wr_busy, wr_ack, wr_err, rd_busy, rd_valid;

  always #5 clk = ~clk;

  jtopl_slot_ring #(.WIDTH(WIDTH), .STAGES(STAGES), .RSTVAL(1'b0), .SW(SW)) dut (
    .rst(rst), .clk(clk), .cen(cen), .slot(slot), .dout(dout),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_req(rd_req), .rd_slot(rd_slot),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  typedef struct {
    int               cyc;
    logic             err;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int   checks = 0, errors = 0, cyc = 0;

  // Reference model: slot contents kept as a plain array indexed by slot
  // number, plus the head slot index and pending host requests.
  int               m_slot = 0;
  logic [WIDTH-1:0] mem [STAGES];
  bit               wp = 0, rp = 0;
  int               wslot = 0, rslot = 0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] last_rd = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) begin
    bit wp0, rp0;
    if (rst) begin
      m_slot = 0;
      for (int i = 0; i < STAGES; i++) mem[i] = '0;
      wp = 0; rp = 0;
      wq.delete(); rq.delete();
    end else begin
      wp0 = wp; rp0 = rp;
      if (rp0 && cen && m_slot == rslot) begin
        rq.push_back('{cyc + 1, 1'b0, mem[rslot]});
        rp = 0;
      end
      if (wp0 && cen && m_slot == wslot) begin
        mem[wslot] = wdata;
        wq.push_back('{cyc + 1, 1'b0, wdata});
        wp = 0;
      end
      if (!wp0 && wr_req) begin
        if (int'(wr_slot) >= STAGES) wq.push_back('{cyc + 1, 1'b1, '0});
        else begin wp = 1; wslot = int'(wr_slot); wdata = wr_data; end
      end
      if (!rp0 && rd_req) begin
        if (int'(rd_slot) >= STAGES) rq.push_back('{cyc + 1, 1'b0, '0});
        else begin rp = 1; rslot = int'(rd_slot); end
      end
      if (cen) m_slot = (m_slot + 1) % STAGES;
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_rd = '0;
    end else begin
      chk("slot", slot, m_slot);
      chk("dout", dout, mem[m_slot]);
      chk("wr_busy", wr_busy, wp);
      chk("rd_busy", rd_busy, rp);
      if (wr_ack) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_ack_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = wq.pop_front();
          chk("wr_ack_cycle", cyc, e.cyc);
          chk("wr_err", wr_err, e.err);
        end
      end else begin
        chk("wr_err_idle", wr_err, 0);
        if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL wr_ack_missing: got 0 expected 1 (cycle %0d)", cyc);
          void'(wq.pop_front());
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_valid_spurious: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = rq.pop_front();
          chk("rd_valid_cycle", cyc, e.cyc);
          chk("rd_data", rd_data, e.data);
          last_rd = e.data;
        end
      end else begin
        chk("rd_data_hold", rd_data, last_rd);
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL rd_valid_missing: got 0 expected 1 (cycle %0d)", cyc);
          void'(rq.pop_front());
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cens(int n);
    cen = 1'b1; step(n); cen = 1'b0;
  endtask

  task automatic wr(int s, int d);
    wr_req = 1'b1; wr_slot = SW'(s); wr_data = WIDTH'(d);
    step(1);
    wr_req = 1'b0;
  endtask

  task automatic rd(int s);
    rd_req = 1'b1; rd_slot = SW'(s);
    step(1);
    rd_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < STAGES; i++) mem[i] = '0;
    step(3);
    chk("reset_slot", slot, 0);
    chk("reset_dout", dout, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    step(1);

    // Full revolution of an empty ring, then move head to slot 2.
    cens(19);
    cens(1);
    chk("head_at_2", slot, 2);

    // Write slot 5 with head at 2, then two revolutions.
    wr(5, 'h1A);
    cens(40);

    // Out-of-range write.
    wr(20, 'h0F);
    step(3);

    // Simultaneous write and read of slot 7.
    wr(7, 'h03);
    cens(20);
    wr_req = 1'b1; wr_slot = 7; wr_data = 'h11;
    rd_req = 1'b1; rd_slot = 7;
    step(1);
    wr_req = 1'b0; rd_req = 1'b0;
    cens(20);
    rd(7);
    cens(20);
    rd(25);
    step(2);

    // Write stalled by a long cen gap.
    wr(3, 'h15);
    step(100);
    cens(20);

    // Reset while both requests are pending.
    wr(9, 'h0C);
    rd(10);
    step(5);
    rst = 1'b1;
    #1;
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_slot", slot, 0);
    chk("rst_dout", dout, 0);
    step(2);
    rst = 1'b0;
    cens(20);

    // Randomized traffic.
    repeat (3000) begin
      cen     = ($urandom_range(0, 9) < 7);
      wr_req  = ($urandom_range(0, 3) == 0);
      wr_slot = SW'($urandom_range(0, 21));
      wr_data = WIDTH'($urandom);
      rd_req  = ($urandom_range(0, 3) == 0);
      rd_slot = SW'($urandom_range(0, 21));
      step(1);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    cens(40);
    step(2);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
